// File: rtl/game_over_overlay_pkg.sv
// Shared display definitions for the game-over overlay: pixel widths, overlay
// state encoding and the per-channel background dimming helper.
package game_over_overlay_pkg;

  localparam int unsigned RGB_W = 12;
  localparam int unsigned CH_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FADE = 2'd1,
    SHOW = 2'd2
  } overlay_state_t;

  // Shift each 4-bit channel right on its own so no bits bleed between channels.
  function automatic logic [RGB_W-1:0] dim_rgb(input logic [RGB_W-1:0] rgb,
                                               input logic [1:0]       sh);
    logic [CH_W-1:0] r_ch;
    logic [CH_W-1:0] g_ch;
    logic [CH_W-1:0] b_ch;
    r_ch = rgb[2*CH_W +: CH_W] >> sh;
    g_ch = rgb[1*CH_W +: CH_W] >> sh;
    b_ch = rgb[0*CH_W +: CH_W] >> sh;
    return {r_ch, g_ch, b_ch};
  endfunction

endpackage

// File: rtl/game_over_overlay_if.sv
// Pixel and control bundle between the timing/text front end and the overlay.
// slave is the overlay's view; master is the driver side.
interface game_over_overlay_if;
  import game_over_overlay_pkg::*;

  logic             frame_start;
  logic             game_over;
  logic             restart_btn;
  logic             in_active;
  logic             pixel_on;
  logic [RGB_W-1:0] bg_rgb;
  logic [RGB_W-1:0] out_rgb;
  logic             out_active;
  logic             overlay_on;
  logic             restart_req;

  modport slave (
    input  frame_start, game_over, restart_btn, in_active, pixel_on, bg_rgb,
    output out_rgb, out_active, overlay_on, restart_req
  );

  modport master (
    output frame_start, game_over, restart_btn, in_active, pixel_on, bg_rgb,
    input  out_rgb, out_active, overlay_on, restart_req
  );

endinterface

// File: rtl/game_over_overlay.sv
// Game-over overlay compositor: passes the playfield through during play, fades
// it out on game over, blinks the text while shown and requests a restart once
// the player has waited long enough. State only moves on frame_start.
module game_over_overlay
  import game_over_overlay_pkg::*;
#(
  parameter int unsigned      FADE_FRAMES  = 8,
  parameter int unsigned      DIM_MAX      = 2,
  parameter int unsigned      BLINK_FRAMES = 30,
  parameter int unsigned      HOLD_FRAMES  = 120,
  parameter logic [RGB_W-1:0] TEXT_RGB     = 12'hF00
) (
  input logic                clk,
  input logic                rst,
  game_over_overlay_if.slave ovl
);

  localparam int unsigned FRAME_W = $clog2(FADE_FRAMES + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES + 1);
  localparam int unsigned HOLD_W  = $clog2(HOLD_FRAMES + 1);

  localparam logic [FRAME_W-1:0] FADE_LAST  = FRAME_W'(FADE_FRAMES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(HOLD_FRAMES);
  localparam logic [1:0]         DIM_TOP    = 2'(DIM_MAX);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_FADE = FADE;
  localparam logic [1:0] S_SHOW = SHOW;

  logic [1:0]         r_state,     w_state_d;
  logic [1:0]         r_dim,       w_dim_d;
  logic [FRAME_W-1:0] r_frame_cnt, w_frame_cnt_d;
  logic [BLINK_W-1:0] r_blink_cnt, w_blink_cnt_d;
  logic [HOLD_W-1:0]  r_hold_cnt,  w_hold_cnt_d;
  logic               r_blink_on,  w_blink_on_d;
  logic               r_go_pend,   w_go_pend_d;
  logic               r_rs_pend,   w_rs_pend_d;
  logic               r_restart,   w_restart_d;
  logic               r_btn_q;
  logic               w_btn_rise;
  logic [RGB_W-1:0]   r_out_rgb;
  logic               r_out_active;
  logic               r_overlay_on;

  assign w_btn_rise = ovl.restart_btn & ~r_btn_q;

  // Next-state: latch events any cycle, act on them only at frame_start.
  always_comb begin
    w_state_d     = r_state;
    w_dim_d       = r_dim;
    w_frame_cnt_d = r_frame_cnt;
    w_blink_cnt_d = r_blink_cnt;
    w_hold_cnt_d  = r_hold_cnt;
    w_blink_on_d  = r_blink_on;
    w_go_pend_d   = r_go_pend;
    w_rs_pend_d   = r_rs_pend;
    w_restart_d   = 1'b0;

    if (r_state == S_IDLE && ovl.game_over) begin
      w_go_pend_d = 1'b1;
    end
    // Early presses are dropped, not queued, so the player must press again.
    if (r_state == S_SHOW && w_btn_rise && r_hold_cnt >= HOLD_MAX) begin
      w_rs_pend_d = 1'b1;
    end

    if (ovl.frame_start) begin
      case (r_state)
        S_IDLE: begin
          w_dim_d = 2'd0;
          if (r_go_pend) begin
            w_state_d     = S_FADE;
            w_go_pend_d   = 1'b0;
            w_frame_cnt_d = '0;
          end
        end
        S_FADE: begin
          if (r_dim >= DIM_TOP) begin
            // Only reachable with DIM_MAX == 0: no fade steps to take.
            w_state_d     = S_SHOW;
            w_hold_cnt_d  = '0;
            w_blink_cnt_d = '0;
            w_blink_on_d  = 1'b1;
          end else if (r_frame_cnt == FADE_LAST) begin
            w_dim_d       = r_dim + 2'd1;
            w_frame_cnt_d = '0;
            if (r_dim + 2'd1 == DIM_TOP) begin
              w_state_d     = S_SHOW;
              w_hold_cnt_d  = '0;
              w_blink_cnt_d = '0;
              w_blink_on_d  = 1'b1;
            end
          end else begin
            w_frame_cnt_d = r_frame_cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (r_rs_pend) begin
            w_state_d   = S_IDLE;
            w_dim_d     = 2'd0;
            w_rs_pend_d = 1'b0;
            w_go_pend_d = 1'b0;
            w_restart_d = 1'b1;
          end else begin
            if (r_hold_cnt != HOLD_MAX) begin
              w_hold_cnt_d = r_hold_cnt + 1'b1;
            end
            if (r_blink_cnt == BLINK_LAST) begin
              w_blink_cnt_d = '0;
              w_blink_on_d  = ~r_blink_on;
            end else begin
              w_blink_cnt_d = r_blink_cnt + 1'b1;
            end
          end
        end
        default: begin
          w_state_d = S_IDLE;
          w_dim_d   = 2'd0;
        end
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dim       <= 2'd0;
      r_frame_cnt <= '0;
      r_blink_cnt <= '0;
      r_hold_cnt  <= '0;
      r_blink_on  <= 1'b1;
      r_go_pend   <= 1'b0;
      r_rs_pend   <= 1'b0;
      r_restart   <= 1'b0;
      r_btn_q     <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_dim       <= w_dim_d;
      r_frame_cnt <= w_frame_cnt_d;
      r_blink_cnt <= w_blink_cnt_d;
      r_hold_cnt  <= w_hold_cnt_d;
      r_blink_on  <= w_blink_on_d;
      r_go_pend   <= w_go_pend_d;
      r_rs_pend   <= w_rs_pend_d;
      r_restart   <= w_restart_d;
      r_btn_q     <= ovl.restart_btn;
    end
  end

  // One-cycle compositing pipeline using the current (pre-update) state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_rgb    <= '0;
      r_out_active <= 1'b0;
      r_overlay_on <= 1'b0;
    end else begin
      r_out_active <= ovl.in_active;
      r_overlay_on <= (r_state == S_FADE) || (r_state == S_SHOW);
      if (!ovl.in_active) begin
        r_out_rgb <= '0;
      end else if (r_state == S_SHOW && r_blink_on && ovl.pixel_on) begin
        r_out_rgb <= TEXT_RGB;
      end else begin
        r_out_rgb <= dim_rgb(ovl.bg_rgb, r_dim);
      end
    end
  end

  assign ovl.out_rgb     = r_out_rgb;
  assign ovl.out_active  = r_out_active;
  assign ovl.overlay_on  = r_overlay_on;
  assign ovl.restart_req = r_restart;

endmodule

// File: tb/tb_game_over_overlay.sv
// Directed bench for game_over_overlay: frames of FL cycles, expected values
// worked out by hand from the overlay's behaviour.
module tb_game_over_overlay;

  localparam int FL = 16;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  game_over_overlay_if ovl_if ();

  game_over_overlay dut (
    .clk (clk),
    .rst (rst),
    .ovl (ovl_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Frame-start cycle; afterwards restart_req shows any pulse from this edge.
  task automatic fs_step();
    ovl_if.frame_start = 1'b1;
    step();
    ovl_if.frame_start = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      fs_step();
      steps(FL - 1);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst                = 1'b1;
    ovl_if.frame_start = 1'b0;
    ovl_if.game_over   = 1'b0;
    ovl_if.restart_btn = 1'b0;
    ovl_if.in_active   = 1'b1;
    ovl_if.pixel_on    = 1'b1;
    ovl_if.bg_rgb      = 12'hABC;
    steps(2);
    chk("rst_rgb", 32'(ovl_if.out_rgb), 32'h0);
    chk("rst_active", 32'(ovl_if.out_active), 32'h0);
    chk("rst_overlay", 32'(ovl_if.overlay_on), 32'h0);
    chk("rst_req", 32'(ovl_if.restart_req), 32'h0);

    rst = 1'b0;
    step();
    chk("pass_rgb", 32'(ovl_if.out_rgb), 32'hABC);
    chk("pass_active", 32'(ovl_if.out_active), 32'h1);
    chk("pass_overlay", 32'(ovl_if.overlay_on), 32'h0);
    steps(3);

    // F0: play; game_over raised mid-frame must not act until F1.
    fs_step();
    step();
    chk("f0_no_text", 32'(ovl_if.out_rgb), 32'hABC);
    steps(4);
    ovl_if.game_over = 1'b1;
    step();
    ovl_if.game_over = 1'b0;
    step();
    chk("f0_still_idle", 32'(ovl_if.overlay_on), 32'h0);
    chk("f0_still_pass", 32'(ovl_if.out_rgb), 32'hABC);
    steps(FL - 8);

    // F1: FADE entered, dim 0.
    ovl_if.bg_rgb = 12'hFFF;
    fs_step();
    step();
    chk("f1_overlay", 32'(ovl_if.overlay_on), 32'h1);
    chk("f1_dim0", 32'(ovl_if.out_rgb), 32'hFFF);
    steps(FL - 2);
    frames(6);
    fs_step();                         // F8
    step();
    chk("f8_dim0", 32'(ovl_if.out_rgb), 32'hFFF);
    steps(FL - 2);
    fs_step();                         // F9
    step();
    chk("f9_dim1", 32'(ovl_if.out_rgb), 32'h777);
    steps(FL - 2);
    frames(7);

    // F17: dim 2 and SHOW, text on.
    fs_step();
    step();
    chk("f17_text", 32'(ovl_if.out_rgb), 32'hF00);
    ovl_if.pixel_on = 1'b0;
    step();
    chk("f17_dim2", 32'(ovl_if.out_rgb), 32'h333);
    ovl_if.in_active = 1'b0;
    step();
    chk("f17_blank", 32'(ovl_if.out_rgb), 32'h0);
    chk("f17_blank_act", 32'(ovl_if.out_active), 32'h0);
    ovl_if.in_active = 1'b1;
    ovl_if.pixel_on  = 1'b1;
    steps(FL - 4);
    frames(28);
    fs_step();                         // F46, SHOW frame 29
    step();
    chk("blink_last_on", 32'(ovl_if.out_rgb), 32'hF00);
    steps(FL - 2);
    fs_step();                         // F47, SHOW frame 30
    step();
    chk("blink_off", 32'(ovl_if.out_rgb), 32'h333);
    steps(FL - 2);
    frames(19);

    // F67 (SHOW frame 50): early press must be discarded.
    fs_step();
    steps(3);
    ovl_if.restart_btn = 1'b1;
    steps(FL - 4);
    fs_step();                         // F68
    chk("early_no_req", 32'(ovl_if.restart_req), 32'h0);
    step();
    chk("early_still_show", 32'(ovl_if.overlay_on), 32'h1);
    ovl_if.restart_btn = 1'b0;
    steps(FL - 2);
    frames(78);

    // F147 (SHOW frame 130): accepted press, acted on at F148.
    fs_step();
    steps(3);
    ovl_if.restart_btn = 1'b1;
    step();
    chk("pend_no_req", 32'(ovl_if.restart_req), 32'h0);
    steps(FL - 5);
    fs_step();                         // F148
    chk("restart_pulse", 32'(ovl_if.restart_req), 32'h1);
    step();
    chk("restart_single", 32'(ovl_if.restart_req), 32'h0);
    chk("restart_idle", 32'(ovl_if.overlay_on), 32'h0);
    chk("restart_pass", 32'(ovl_if.out_rgb), 32'hFFF);
    ovl_if.restart_btn = 1'b0;
    steps(FL - 2);
    fs_step();                         // F149
    step();
    chk("idle_stays", 32'(ovl_if.overlay_on), 32'h0);
    steps(3);
    ovl_if.game_over = 1'b1;
    step();
    ovl_if.game_over = 1'b0;
    steps(FL - 6);

    // F150 enters FADE; F158 reaches dim 1; reset mid-frame.
    frames(8);
    fs_step();
    step();
    chk("fade2_dim1", 32'(ovl_if.out_rgb), 32'h777);
    rst = 1'b1;
    step();
    chk("midrst_rgb", 32'(ovl_if.out_rgb), 32'h0);
    chk("midrst_overlay", 32'(ovl_if.overlay_on), 32'h0);
    chk("midrst_req", 32'(ovl_if.restart_req), 32'h0);
    rst = 1'b0;
    step();
    chk("postrst_pass", 32'(ovl_if.out_rgb), 32'hFFF);
    steps(FL - 4);
    fs_step();
    step();
    chk("postrst_idle", 32'(ovl_if.overlay_on), 32'h0);
    chk("postrst_undim", 32'(ovl_if.out_rgb), 32'hFFF);
    steps(3);

    // game_over held through a full fade/show/restart cycle.
    ovl_if.game_over = 1'b1;
    steps(FL - 5);
    frames(16);                        // G0 (FADE) .. G15
    frames(120);                       // G16 (SHOW) .. G135
    fs_step();                         // G136, hold saturated
    steps(3);
    ovl_if.restart_btn = 1'b1;
    steps(FL - 4);
    fs_step();                         // G137
    chk("hold_go_pulse", 32'(ovl_if.restart_req), 32'h1);
    step();
    chk("hold_go_idle", 32'(ovl_if.overlay_on), 32'h0);
    ovl_if.restart_btn = 1'b0;
    steps(FL - 2);
    fs_step();                         // G138
    step();
    chk("refade", 32'(ovl_if.overlay_on), 32'h1);
    chk("refade_dim0", 32'(ovl_if.out_rgb), 32'hFFF);
    ovl_if.game_over = 1'b0;
    steps(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
